// File: rtl/riscv_dmem.sv
// Data-memory responder for the RV32I core: valid/ready request, WAIT_CYCLES wait states,
// byte-lane masked access, one-cycle response strobe. Misalignment check: RISCV_DMEM_MISALIGN_CHK_EN.
module riscv_dmem #(
  parameter int DWIDTH      = 32,
  parameter int AWIDTH      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_dmem_req,
  output logic              o_dmem_ready,
  input  logic              i_dmem_wr_en,
  input  logic [3:0]        i_dmem_byte_sel,
  input  logic [31:0]       i_dmem_addr,
  input  logic [DWIDTH-1:0] i_dmem_wr_data,
  output logic [DWIDTH-1:0] o_dmem_rd_data,
  output logic              o_dmem_rsp_valid,
  output logic              o_dmem_err
);

  // state    | meaning
  // S_IDLE   | ready, waiting for a request
  // S_WAIT   | counting down wait states
  // S_ACCESS | write commit / read capture at the exit edge
  // S_RESP   | rsp_valid strobe, rd_data and err valid
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [AWIDTH+1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [3:0]        sel_q, sel_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d;
  logic [DWIDTH-1:0] rd_data_q, rd_data_d;
  logic              rsp_q, rsp_d;
  logic              err_q, err_d;

  logic [DWIDTH-1:0] mem [2**AWIDTH];

  logic [1:0]        off;
  logic [AWIDTH-1:0] idx;
  logic [3:0]        mask;
  logic              blocked;
  logic [DWIDTH-1:0] lane_bits, wdata_sh, word, merged, rd_sh, rd_masked;
  logic              do_write;
  logic              unused_addr;

  assign unused_addr = ^i_dmem_addr[31:AWIDTH+2];
  assign off  = addr_q[1:0];
  assign idx  = addr_q[AWIDTH+1:2];

`ifdef RISCV_DMEM_MISALIGN_CHK_EN
  logic [7:0] sel_sh;
  assign sel_sh  = {4'b0000, sel_q} << off;
  assign mask    = sel_sh[3:0];
  // Any lane pushed past byte 3 makes the whole access illegal.
  assign blocked = |sel_sh[7:4];
`else
  assign mask    = sel_q << off;
  assign blocked = 1'b0;
`endif

  always_comb begin
    lane_bits = '0;
    rd_masked = '0;
    for (int i = 0; i < 4; i++) begin
      lane_bits[8*i +: 8] = {8{mask[i]}};
    end
    wdata_sh = wdata_q << {off, 3'b000};
    word     = mem[idx];
    merged   = we_q ? ((word & ~lane_bits) | (wdata_sh & lane_bits)) : word;
    rd_sh    = merged >> {off, 3'b000};
    for (int i = 0; i < 4; i++) begin
      rd_masked[8*i +: 8] = sel_q[i] ? rd_sh[8*i +: 8] : 8'h00;
    end
  end

  assign do_write = (state_q == S_ACCESS) && we_q && !blocked;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    we_d      = we_q;
    sel_d     = sel_q;
    wdata_d   = wdata_q;
    rd_data_d = rd_data_q;
    rsp_d     = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_dmem_req) begin
          addr_d  = i_dmem_addr[AWIDTH+1:0];
          we_d    = i_dmem_wr_en;
          sel_d   = i_dmem_byte_sel;
          wdata_d = i_dmem_wr_data;
          if (WAIT_CYCLES > 0) begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_CYCLES);
          end else begin
            state_d = S_ACCESS;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        state_d   = S_RESP;
        rsp_d     = 1'b1;
        err_d     = blocked;
        rd_data_d = blocked ? '0 : rd_masked;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      sel_q     <= 4'd0;
      wdata_q   <= '0;
      rd_data_q <= '0;
      rsp_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      wdata_q   <= wdata_d;
      rd_data_q <= rd_data_d;
      rsp_q     <= rsp_d;
      err_q     <= err_d;
    end
  end

  // Reset at the commit edge discards the pending store.
  always_ff @(posedge i_clk) begin
    if (i_rstn && do_write) begin
      mem[idx] <= merged;
    end
  end

  assign o_dmem_ready     = (state_q == S_IDLE);
  assign o_dmem_rd_data   = rd_data_q;
  assign o_dmem_rsp_valid = rsp_q;
  assign o_dmem_err       = err_q;

endmodule

// File: tb/tb_riscv_dmem.sv
// Self-checking bench for riscv_dmem: directed steps plus randomized accesses against a
// byte-level reference memory. Honours RISCV_DMEM_MISALIGN_CHK_EN.
module tb_riscv_dmem;
  localparam int WAIT = 1;
`ifdef RISCV_DMEM_MISALIGN_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rstn;
  logic        i_dmem_req;
  logic        o_dmem_ready;
  logic        i_dmem_wr_en;
  logic [3:0]  i_dmem_byte_sel;
  logic [31:0] i_dmem_addr;
  logic [31:0] i_dmem_wr_data;
  logic [31:0] o_dmem_rd_data;
  logic        o_dmem_rsp_valid;
  logic        o_dmem_err;

  int n_cmp  = 0;
  int n_fail = 0;
  byte unsigned mdl [4096];

  always #5 i_clk = ~i_clk;

  riscv_dmem #(.DWIDTH(32), .AWIDTH(10), .WAIT_CYCLES(WAIT)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_dmem_req(i_dmem_req), .o_dmem_ready(o_dmem_ready),
    .i_dmem_wr_en(i_dmem_wr_en), .i_dmem_byte_sel(i_dmem_byte_sel), .i_dmem_addr(i_dmem_addr),
    .i_dmem_wr_data(i_dmem_wr_data), .o_dmem_rd_data(o_dmem_rd_data),
    .o_dmem_rsp_valid(o_dmem_rsp_valid), .o_dmem_err(o_dmem_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Byte-level model: memory is 4096 bytes, address bits above 11 alias away.
  function automatic void mdl_access(input bit we, input logic [3:0] sel, input logic [31:0] addr,
                                     input logic [31:0] data, output logic [31:0] rd, output logic err);
    int off  = int'(addr[1:0]);
    int base = int'(addr[11:2]) * 4;
    bit mis  = 1'b0;
    for (int j = 0; j < 4; j++) if (sel[j] && off + j > 3) mis = 1'b1;
    err = CHK && mis;
    if (we && !err)
      for (int j = 0; j < 4; j++) if (sel[j] && off + j < 4) mdl[base + off + j] = data[8*j +: 8];
    rd = '0;
    if (!err)
      for (int j = 0; j < 4; j++) if (sel[j] && off + j < 4) rd[8*j +: 8] = mdl[base + off + j];
  endfunction

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!o_dmem_ready && n < 50) begin
      @(posedge i_clk); #1; n++;
    end
    check({tag, "_ready_wait"}, 32'(o_dmem_ready), 32'd1);
  endtask

  task automatic xact(input bit we, input logic [3:0] sel, input logic [31:0] addr,
                      input logic [31:0] data, input string tag,
                      output logic [31:0] rd, output logic err);
    int lat = 0;
    int k   = 1;
    bit rdy_bad = 1'b0;
    wait_ready(tag);
    i_dmem_wr_en = we; i_dmem_byte_sel = sel; i_dmem_addr = addr; i_dmem_wr_data = data;
    i_dmem_req = 1'b1;
    @(posedge i_clk); #1;
    i_dmem_req = 1'b0;
    i_dmem_wr_en = 1'($urandom); i_dmem_byte_sel = 4'($urandom);
    i_dmem_addr = $urandom; i_dmem_wr_data = $urandom;
    while (k <= WAIT + 6 && lat == 0) begin
      if (o_dmem_ready) rdy_bad = 1'b1;
      if (o_dmem_rsp_valid) lat = k;
      else begin
        @(posedge i_clk); #1; k++;
      end
    end
    rd  = o_dmem_rd_data;
    err = o_dmem_err;
    check({tag, "_latency"}, 32'(lat), 32'(WAIT + 2));
    check({tag, "_ready_low"}, 32'(rdy_bad), 32'd0);
    @(posedge i_clk); #1;
    check({tag, "_strobe_drop"}, {o_dmem_rsp_valid, o_dmem_ready}, 32'b01);
    check({tag, "_rd_hold"}, o_dmem_rd_data, rd);
  endtask

  task automatic op(input bit we, input logic [3:0] sel, input logic [31:0] addr,
                    input logic [31:0] data, input string tag, output logic [31:0] rd);
    logic [31:0] exp_rd;
    logic exp_err, err;
    mdl_access(we, sel, addr, data, exp_rd, exp_err);
    xact(we, sel, addr, data, tag, rd, err);
    if (!we) check({tag, "_rd"}, rd, exp_rd);
    check({tag, "_err"}, 32'(err), 32'(exp_err));
  endtask

  task automatic abort_op(input logic [31:0] addr, input logic [31:0] data, input int phase,
                          input string tag);
    int rsp_seen = 0;
    wait_ready(tag);
    i_dmem_wr_en = 1'b1; i_dmem_byte_sel = 4'b1111; i_dmem_addr = addr; i_dmem_wr_data = data;
    i_dmem_req = 1'b1;
    @(posedge i_clk); #1;
    i_dmem_req = 1'b0;
    for (int i = 1; i < phase; i++) begin
      @(posedge i_clk); #1;
    end
    i_rstn = 1'b0;
    @(posedge i_clk); #1;
    i_rstn = 1'b1;
    check({tag, "_ready_after_rst"}, 32'(o_dmem_ready), 32'd1);
    check({tag, "_rd_after_rst"}, o_dmem_rd_data, 32'd0);
    for (int i = 0; i < 6; i++) begin
      if (o_dmem_rsp_valid) rsp_seen++;
      @(posedge i_clk); #1;
    end
    check({tag, "_no_rsp"}, 32'(rsp_seen), 32'd0);
  endtask

  logic [31:0] rd;
  logic [31:0] exp_w;

  initial begin
    int acc_n, rsp_n;
    i_rstn = 1'b0; i_dmem_req = 1'b0; i_dmem_wr_en = 1'b0;
    i_dmem_byte_sel = 4'd0; i_dmem_addr = '0; i_dmem_wr_data = '0;
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_ready", 32'(o_dmem_ready), 32'd1);
    check("rst_rsp", 32'(o_dmem_rsp_valid), 32'd0);
    check("rst_rd", o_dmem_rd_data, 32'd0);
    check("rst_err", 32'(o_dmem_err), 32'd0);
    i_rstn = 1'b1;
    @(posedge i_clk); #1;

    op(1'b1, 4'b1111, 32'h10, 32'hDEADBEEF, "t1_sw", rd);
    op(1'b0, 4'b1111, 32'h10, 32'h0, "t1_lw", rd);
    check("t1_lw_const", rd, 32'hDEADBEEF);

    op(1'b1, 4'b1111, 32'h10, 32'h11223344, "t2_sw", rd);
    op(1'b1, 4'b0001, 32'h13, 32'h000000A5, "t2_sb", rd);
    op(1'b0, 4'b1111, 32'h10, 32'h0, "t2_lw", rd);
    check("t2_lw_const", rd, 32'hA5223344);
    op(1'b0, 4'b0001, 32'h13, 32'h0, "t2_lb", rd);
    check("t2_lb_const", rd, 32'h000000A5);

    op(1'b1, 4'b1111, 32'h20, 32'h11223344, "t3_sw", rd);
    op(1'b1, 4'b0011, 32'h22, 32'h0000BEEF, "t3_sh", rd);
    op(1'b0, 4'b1111, 32'h20, 32'h0, "t3_lw", rd);
    check("t3_lw_const", rd, 32'hBEEF3344);
    op(1'b0, 4'b0011, 32'h20, 32'h0, "t3_lh", rd);
    check("t3_lh_const", rd, 32'h00003344);

    op(1'b1, 4'b1111, 32'h30, 32'h00000000, "t4_clr", rd);
    op(1'b1, 4'b1111, 32'h31, 32'hAABBCCDD, "t4_sw_mis", rd);
    op(1'b0, 4'b1111, 32'h30, 32'h0, "t4_lw", rd);
    exp_w = CHK ? 32'h00000000 : 32'hBBCCDD00;
    check("t4_lw_const", rd, exp_w);
    op(1'b0, 4'b0000, 32'h30, 32'h0, "t4_sel0", rd);
    check("t4_sel0_const", rd, 32'h0);

    op(1'b1, 4'b1111, 32'h40, 32'h0BADF00D, "t5_pre", rd);
    abort_op(32'h40, 32'h12345678, 1, "t5_wait");
    abort_op(32'h40, 32'h87654321, 2, "t5_access");
    op(1'b0, 4'b1111, 32'h40, 32'h0, "t5_lw", rd);
    check("t5_lw_const", rd, 32'h0BADF00D);

    op(1'b1, 4'b1111, 32'h1000, 32'hCAFEF00D, "t6_sw", rd);
    op(1'b0, 4'b1111, 32'h0000, 32'h0, "t6_lw", rd);
    check("t6_alias_const", rd, 32'hCAFEF00D);

    wait_ready("t6_tp");
    i_dmem_wr_en = 1'b0; i_dmem_byte_sel = 4'b1111; i_dmem_addr = 32'h0; i_dmem_req = 1'b1;
    acc_n = 0; rsp_n = 0;
    for (int c = 0; c < 16; c++) begin
      if (o_dmem_ready && i_dmem_req) acc_n++;
      if (o_dmem_rsp_valid) begin
        rsp_n++;
        check("t6_tp_rd", o_dmem_rd_data, 32'hCAFEF00D);
      end
      @(posedge i_clk); #1;
    end
    i_dmem_req = 1'b0;
    check("t6_tp_accepts", 32'(acc_n), 32'd4);
    check("t6_tp_rsps", 32'(rsp_n), 32'd4);

    for (int w = 0; w < 16; w++)
      op(1'b1, 4'b1111, 32'h100 + 32'(w * 4), $urandom, "rnd_init", rd);
    for (int n = 0; n < 60; n++) begin
      logic [3:0]  sel;
      logic [31:0] addr;
      bit          we;
      case ($urandom_range(0, 4))
        0: sel = 4'b0001;
        1: sel = 4'b0011;
        2: sel = 4'b1111;
        3: sel = 4'b0000;
        default: sel = 4'($urandom);
      endcase
      addr = ($urandom & 32'hFFFF_F000) | 32'h100 | 32'($urandom_range(0, 15) * 4)
             | 32'($urandom_range(0, 3));
      we = 1'($urandom);
      op(we, sel, addr, $urandom, "rnd", rd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
